// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - memory-mapped 64-bit timer with prescaler, compare and interrupt
module mmio_timer #(
   parameter int PRESCALE_W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         we,
   input  logic [2:0]   wsel,
   input  logic [255:0] mem_wd,
   output logic [255:0] mem_rd,
   output logic         irq
);

   logic [63:0]           mtime;
   logic [63:0]           mtimecmp;
   logic                  en;
   logic                  ie;
   logic                  pending;
   logic [PRESCALE_W-1:0] div;
   logic [PRESCALE_W-1:0] pcnt;
   logic [31:0]           wd;
   logic                  tick;
   logic                  cmp_hit;

   assign wd      = mem_wd[{wsel, 5'b00000} +: 32];
   assign tick    = en && (pcnt == div);
   assign cmp_hit = (mtime >= mtimecmp);

   // Write cases come after the count update so a same-edge write to a
   // time half overrides the increment; other writes leave it in place.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mtime    <= '0;
         mtimecmp <= '1;
         en       <= 1'b0;
         ie       <= 1'b0;
         div      <= '0;
         pcnt     <= '0;
         pending  <= 1'b0;
         irq      <= 1'b0;
      end else begin
         pending <= cmp_hit;
         irq     <= ie & cmp_hit;
         if (tick) begin
            mtime <= mtime + 64'd1;
            pcnt  <= '0;
         end else if (en) begin
            pcnt <= pcnt + PRESCALE_W'(1);
         end
         if (we) begin
            case (wsel)
               3'd0: begin
                  mtime <= {mtime[63:32], wd};
                  pcnt  <= '0;
               end
               3'd1: begin
                  mtime <= {wd, mtime[31:0]};
                  pcnt  <= '0;
               end
               3'd2: mtimecmp[31:0]  <= wd;
               3'd3: mtimecmp[63:32] <= wd;
               3'd4: begin
                  en <= wd[0];
                  ie <= wd[1];
               end
               3'd6: begin
                  div  <= wd[PRESCALE_W-1:0];
                  pcnt <= '0;
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      mem_rd          = '0;
      mem_rd[31:0]    = mtime[31:0];
      mem_rd[63:32]   = mtime[63:32];
      mem_rd[95:64]   = mtimecmp[31:0];
      mem_rd[127:96]  = mtimecmp[63:32];
      mem_rd[159:128] = {30'd0, ie, en};
      mem_rd[191:160] = {30'd0, en, pending};
      mem_rd[223:192] = 32'(div);
   end

endmodule

// File: doc/mmio_timer.md
MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 16, width of the prescaler divisor and counter.
REQ-002 SHALL have one clock and an asynchronous, active-high reset: port clk (input, 1, rising-edge clock) listed first, then rst (input, 1, asynchronous active-high reset).
REQ-003 SHALL have port we  input  1  write strobe from the word-mapping stage.
REQ-004 SHALL have port wsel  input  3  word index of the current access, equal to bus addr[4:2].
REQ-005 SHALL have port mem_wd  input  256  eight 32-bit next-value words; word n occupies bits [32n+31:32n].
REQ-006 SHALL have port mem_rd  output  256  eight 32-bit current-value words, same packing as mem_wd.
REQ-007 SHALL have port irq  output  1  registered timer interrupt request.

Function
REQ-008 SHALL use this word map:
- word0: mtime[31:0]
- word1: mtime[63:32]
- word2: mtimecmp[31:0]
- word3: mtimecmp[63:32]
- word4: ctrl; bit0 = EN (count enable), bit1 = IE (interrupt enable), bits[31:2] read 0
- word5: status, read-only; bit0 = pending, bit1 = EN copy, bits[31:2] read 0
- word6: div; bits[PRESCALE_W-1:0] divisor, upper bits read 0
- word7: reserved, reads 0
REQ-009 SHALL drive mem_rd combinationally from the internal registers with no added latency.
REQ-010 SHALL, on a rising edge with we=1, load only the word selected by wsel from mem_wd[32*wsel +: 32]; all other words are unaffected even though mem_wd carries them.
REQ-011 SHALL ignore writes to word5 and word7; for word4 and word6, only defined bits are stored.
REQ-012 SHALL keep a prescaler counter pcnt[PRESCALE_W-1:0]; a tick occurs in a cycle where EN=1 and pcnt==div.
REQ-013 On a tick, SHALL set pcnt to 0 and increment mtime by 1 at the same edge; otherwise, when EN=1, SHALL increment pcnt; when EN=0, SHALL hold pcnt and mtime.
REQ-014 With div=0, SHALL tick every cycle while EN=1; with div=N, SHALL increment mtime once every N+1 cycles.
REQ-015 SHALL perform mtime increment as full 64-bit unsigned arithmetic with carry from bit 31 into bit 32, wrapping 0xFFFFFFFF_FFFFFFFF to 0.
REQ-016 On a write to word0 or word1 coinciding with a tick, SHALL have the written half take the written value and the other half keep its pre-edge value, with no increment applied; pcnt SHALL be cleared.
REQ-017 On a write to word2, word3, word4 or word6 coinciding with a tick, SHALL still apply the mtime increment.
REQ-018 On any write to word6, SHALL clear pcnt to 0.
REQ-019 SHALL register pending each edge as the unsigned compare (mtime >= mtimecmp) of the pre-edge register values; pending is level-sensitive and SHALL be cleared only by making the compare false.
REQ-020 SHALL register irq each edge as IE & (mtime >= mtimecmp) of the pre-edge values, asserting one cycle after the compare becomes true and deasserting one cycle after it becomes false or IE is cleared.
REQ-021 Pending and irq evaluation SHALL be independent of EN.

Reset
REQ-022 Asynchronous rst assertion SHALL immediately set: mtime=0; mtimecmp=0xFFFFFFFF_FFFFFFFF; ctrl=0; div=0; pcnt=0; pending=0; irq=0.
REQ-023 mem_rd SHALL show these reset values while rst=1, and SHALL ignore we while rst=1.
REQ-024 Reset asserted mid-count SHALL abandon the count; after release, the first tick SHALL require EN to be written again.

Verification
REQ-025 Reset, write ctrl=0x1, div=0 -> word0 reads 1, 2, 3 on successive cycles after the enabling edge; irq stays 0.
REQ-026 div=3, EN=1 for 12 cycles -> mtime=3, with increments spaced exactly 4 cycles apart.
REQ-027 mtime=0x00000000_FFFFFFFE, div=0, EN=1 -> after two ticks word1=0x00000001 and word0=0x00000000.
REQ-028 mtimecmp=5, IE=1, EN=1, div=0 from mtime=0 -> irq rises one cycle after mtime reads 5; then writing word3=0xFFFFFFFF -> irq falls one cycle later.
REQ-029 Write word2 in the same cycle as a tick -> mtime still increments; write word0=0x10 in a tick cycle -> word0 reads 0x10 the next cycle, not 0x11.
REQ-030 Assert rst while EN=1 and mtime=0x1234 -> all outputs read reset values immediately; after release with no writes, mtime stays 0 for 10 cycles.
